// File: rtl/mod_div_seq.sv
// Sequential radix-2 restoring divider producing quotient and remainder together.
// Handles unsigned and two's-complement operands and flags divide-by-zero and signed MIN/-1.
module mod_div_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic             overflow
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_DIV  = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

  function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] x);
    return ~x + WIDTH'(1);
  endfunction

  // |MIN| is 2^(WIDTH-1), which still fits as an unsigned WIDTH-bit magnitude.
  function automatic logic [WIDTH-1:0] mag_w(input logic signed [WIDTH-1:0] x,
                                             input logic sgn);
    logic [WIDTH-1:0] r;
    r = x;
    if (sgn && x[WIDTH-1]) r = neg_w(x);
    return r;
  endfunction

  // Control state
  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             q_neg_q, q_neg_d;
  logic             r_neg_q, r_neg_d;
  logic             ovf_q, ovf_d;

  // Datapath state
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dmag_q, dmag_d;

  // Result registers
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             dbz_q, dbz_d;
  logic             overflow_q, overflow_d;

  logic [WIDTH:0]   rem_sh;
  logic             borrow;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    q_neg_d     = q_neg_q;
    r_neg_d     = r_neg_q;
    ovf_d       = ovf_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    dmag_d      = dmag_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;
    overflow_d  = overflow_q;
    rem_sh      = {rem_q, quo_q[WIDTH-1]};
    borrow      = rem_sh < {1'b0, dmag_q};

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (divisor == '0) begin
            quotient_d  = '1;
            remainder_d = dividend;
            dbz_d       = 1'b1;
            overflow_d  = 1'b0;
            state_d     = S_DONE;
          end else begin
            dmag_d  = mag_w(divisor, signed_mode);
            quo_d   = mag_w(dividend, signed_mode);
            rem_d   = '0;
            cnt_d   = '0;
            q_neg_d = signed_mode & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
            r_neg_d = signed_mode & dividend[WIDTH-1];
            ovf_d   = signed_mode & (dividend == MIN_VAL) & (divisor == '1);
            state_d = S_DIV;
          end
        end
      end
      S_DIV: begin
        // The remainder always stays below the divisor magnitude, so the low WIDTH bits of the difference are exact.
        if (!borrow) begin
          rem_d = rem_sh[WIDTH-1:0] - dmag_q;
          quo_d = {quo_q[WIDTH-2:0], 1'b1};
        end else begin
          rem_d = rem_sh[WIDTH-1:0];
          quo_d = {quo_q[WIDTH-2:0], 1'b0};
        end
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_ITER) state_d = S_FIX;
      end
      S_FIX: begin
        quotient_d  = q_neg_q ? neg_w(quo_q) : quo_q;
        remainder_d = r_neg_q ? neg_w(rem_q) : rem_q;
        dbz_d       = 1'b0;
        overflow_d  = ovf_q;
        state_d     = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      q_neg_q     <= 1'b0;
      r_neg_q     <= 1'b0;
      ovf_q       <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      q_neg_q     <= q_neg_d;
      r_neg_q     <= r_neg_d;
      ovf_q       <= ovf_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
      overflow_q  <= overflow_d;
    end
  end

  // Working registers are only meaningful between launch and FIX, so they carry no reset.
  always_ff @(posedge clk) begin
    rem_q  <= rem_d;
    quo_q  <= quo_d;
    dmag_q <= dmag_d;
  end

  assign busy        = (state_q != S_IDLE);
  assign done        = (state_q == S_DONE);
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = dbz_q;
  assign overflow    = overflow_q;

endmodule
